// File: rtl/stream_mux_n.sv
// stream_mux_n: NCH-to-1 stream mux with fixed or round-robin grant and a single registered output slot
module stream_mux_n #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  ch_q, ch_d, ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  rr_grant, grant, idx;
    logic             found, grant_valid, load_en, in_xfer;
    // NCH is a power of two, so SELW-bit addition wraps the search modulo NCH
    always_comb begin
        rr_grant = ptr_q;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr_q + SELW'(k);
            if (!found && in_valid[idx]) begin
                rr_grant = idx;
                found    = 1'b1;
            end
        end
    end
    always_comb begin
        load_en     = !valid_q || out_ready;
        grant       = mode ? rr_grant : sel;
        grant_valid = mode ? |in_valid : in_valid[sel];
        in_xfer     = rst_n && load_en && grant_valid;
        in_ready    = in_xfer ? NCH'(1) << grant : '0;
        data_d      = in_xfer ? in_data[grant*WIDTH +: WIDTH] : data_q;
        ch_d        = in_xfer ? grant : ch_q;
        valid_d     = in_xfer ? 1'b1 : (out_ready ? 1'b0 : valid_q);
        ptr_d       = (in_xfer && mode) ? grant + SELW'(1) : ptr_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: directed scoreboard bench for stream_mux_n (WIDTH=8, NCH=4)
module tb_stream_mux_n;
    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 2;
    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic [S-1:0]   sel, out_ch;
    logic           mode, out_valid, out_ready;
    logic [W-1:0]   out_data;
    int             total = 0;
    int             bad = 0;
    logic [S+W-1:0] q[$];

    stream_mux_n #(.WIDTH(W), .NCH(N), .SELW(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: check output against scoreboard, check grant, record accepted words
    task automatic cyc(input logic [N-1:0] er);
        logic [S+W-1:0] e;
        @(negedge clk);
        chk("out_valid_vs_sb", 32'(out_valid), 32'(q.size() != 0));
        if (out_valid && out_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("out_data", 32'(out_data), 32'(e[W-1:0]));
            chk("out_ch", 32'(out_ch), 32'(e[S+W-1:W]));
        end
        chk("in_ready", 32'(in_ready), 32'(er));
        for (int i = 0; i < N; i++)
            if (er[i]) q.push_back({S'(i), in_data[i*W +: W]});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        in_valid = 4'hf; sel = '0; mode = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ch", 32'(out_ch), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        in_valid = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        // fixed select, channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'hf;
        repeat (3) cyc(4'b0100);
        // round-robin, all valid; ptr starts at 0
        mode = 1'b1;
        cyc(4'b0001); cyc(4'b0010); cyc(4'b0100); cyc(4'b1000); cyc(4'b0001); cyc(4'b0010);
        // sparse valid, ptr=2 -> 3, wraps -> 1, 3, 1
        in_valid = 4'b1010;
        cyc(4'b1000); cyc(4'b0010); cyc(4'b1000); cyc(4'b0010);
        // backpressure on a held 0x22
        mode = 1'b0; sel = 2'd1; in_valid = 4'hf;
        cyc(4'b0010);
        out_ready = 1'b0; sel = 2'd3;
        repeat (3) begin
            in_data = {$urandom, $urandom};
            in_valid = 4'($urandom_range(1, 15));
            cyc(4'b0000);
            chk("hold_data", 32'(out_data), 32'h22);
            chk("hold_valid", 32'(out_valid), 1);
        end
        in_data = {8'h44, 8'h33, 8'h22, 8'h11}; in_valid = 4'hf; out_ready = 1'b1;
        cyc(4'b1000);
        in_valid = '0;
        cyc(4'b0000); cyc(4'b0000);
        // mode switch while a ch2 word is stalled; ptr=2
        mode = 1'b1; in_valid = 4'b0100;
        cyc(4'b0100);
        out_ready = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'hf;
        cyc(4'b0000);
        chk("stall_ch", 32'(out_ch), 2);
        chk("stall_data", 32'(out_data), 32'h33);
        out_ready = 1'b1;
        cyc(4'b0001); cyc(4'b0001);
        in_valid = '0;
        cyc(4'b0000);
        // valid on unselected channels only: no grant, no state change
        in_valid = 4'b1110;
        cyc(4'b0000); cyc(4'b0000);
        // ptr=3, valid 0 and 2 -> grant 0, ptr becomes 1; then async reset mid-word
        mode = 1'b1; in_valid = 4'b0101;
        cyc(4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_ch", 32'(out_ch), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        q.delete();
        @(posedge clk);
        #1 chk("rst_hold_in_ready", 32'(in_ready), 0);
        #2 rst_n = 1'b1;
        // ptr cleared to 0 -> channel 0 wins over 1
        in_valid = 4'b0011;
        cyc(4'b0001);
        in_valid = 4'b1000;
        cyc(4'b1000);
        in_valid = '0;
        cyc(4'b0000); cyc(4'b0000);
        chk("sb_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_mux_n.md
STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 Parameter WIDTH, default 8, data width per channel in bits (1..64).
REQ-002 Parameter NCH, default 4, number of input channels, power of two, 2..16.
REQ-003 Parameter SELW, default 2, select/channel-index width; SHALL equal log2(NCH).
REQ-004 Port clk  input  1  single clock for all state; rising-edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid  input  NCH  per-channel valid.
REQ-008 Port in_ready  output  NCH  per-channel ready, combinational.
REQ-009 Port sel  input  SELW  channel select in fixed mode.
REQ-010 Port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-011 Port out_data  output  WIDTH  registered selected data.
REQ-012 Port out_valid  output  1  registered output valid.
REQ-013 Port out_ready  input  1  downstream ready.
REQ-014 Port out_ch  output  SELW  registered index of channel that supplied out_data.

Function
REQ-015 Transfer on any port SHALL occur only on a rising clk edge with valid and ready both high.
REQ-016 load_en SHALL equal (!out_valid || out_ready); output register loads only when load_en.
REQ-017 Fixed mode: grant = sel; grant_valid = in_valid[sel]; other channels never granted.
REQ-018 Round-robin mode: grant = first channel with in_valid high searching ptr, ptr+1, ... NCH-1, 0, ... ptr-1; grant_valid = |in_valid.
REQ-019 ptr SHALL update to (grant+1) mod NCH on every input transfer in round-robin mode, wrapping NCH-1 -> 0; unchanged otherwise, and unchanged in fixed mode.
REQ-020 in_ready[i] SHALL be high iff load_en && grant_valid && grant==i; at most one in_ready bit high per cycle.
REQ-021 On input transfer, out_data <= in_data[grant], out_ch <= grant, out_valid <= 1, next edge (latency 1 cycle).
REQ-022 Output transfer without input transfer SHALL clear out_valid; out_data, out_ch hold last value.
REQ-023 Simultaneous output and input transfer in one cycle SHALL replace the word; out_valid stays 1; sustained throughput 1 word/cycle.
REQ-024 While out_valid && !out_ready, out_data, out_ch, out_valid SHALL hold stable and all in_ready low.
REQ-025 Changes of mode or sel SHALL affect only the next grant, never a word already in the output register.
REQ-026 No input data SHALL be duplicated or dropped; a channel holding in_valid in round-robin mode SHALL be granted within NCH transfers.
REQ-027 in_valid asserted with no grant SHALL not alter any state.

Reset
REQ-028 rst_n low SHALL immediately and asynchronously force out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-029 While rst_n low, all in_ready SHALL be low regardless of inputs.
REQ-030 Reset mid-operation SHALL discard the held output word; first grant after release follows REQ-017/018 with ptr=0.
REQ-031 Reset deassertion SHALL take effect at the first rising clk edge after rst_n high; no transfer on that edge if rst_n rose coincident with it.

Verification (WIDTH=8, NCH=4)
REQ-032 Fixed mode, sel=2, in_valid=4'b1111, in_data ch0..3=0x11,0x22,0x33,0x44, out_ready=1 -> in_ready=4'b0100, next cycle out_data=0x33, out_ch=2, out_valid=1, each cycle.
REQ-033 Round-robin, all channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, one word per cycle.
REQ-034 Round-robin, in_valid=4'b1010, ptr=0 -> grants 1,3,1,3; ptr wraps 3 -> 0 -> grant 1.
REQ-035 Backpressure: out_valid=1 with out_data=0x22, out_ready=0 for 3 cycles while inputs change -> out_data stays 0x22, in_ready=0; out_ready=1 -> new word loaded same edge.
REQ-036 Assert rst_n low mid-stream between clk edges -> out_valid, out_data, out_ch go 0 immediately; after release with ch3 only valid, round-robin -> out_ch=3 after one cycle.
REQ-037 Switch mode 1 -> 0 with sel=0 while a ch2 word is held and stalled -> held word delivered as 0x33/out_ch=2, then only ch0 granted.
